// File: rtl/apu_audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apu_audio_pkg
//  Description : Shared audio constants, transmitter state encoding and the
//                unsigned-to-signed left-justify conversion for I2S slots.
//  Revision    : 1.0 - initial release
// ============================================================================
package apu_audio_pkg;

    // Mixer output width; kept here so the transmitter tracks the mixer.
    localparam int SAMPLE_WIDTH   = 9;
    localparam int I2S_SLOT_WIDTH = 16;

    // Widest slot the conversion helper can produce.
    localparam int c_CONV_MAX_W   = 32;

    typedef enum logic [0:0] {
        ST_RESET = 1'b0,
        ST_RUN   = 1'b1
    } i2s_state_t;

    // Flip the sample MSB (offset binary -> two's complement), then shift it
    // up so the sample MSB lands on the slot MSB. Mute forces signed silence.
    function automatic logic [c_CONV_MAX_W-1:0] sample_to_slot(
        input logic [c_CONV_MAX_W-1:0] sample,
        input int                      sample_w,
        input int                      slot_w,
        input logic                    mute
    );
        logic [c_CONV_MAX_W-1:0] r;
        r = sample & ((c_CONV_MAX_W'(1) << sample_w) - c_CONV_MAX_W'(1));
        r = r ^ (c_CONV_MAX_W'(1) << (sample_w - 1));
        r = r << (slot_w - sample_w);
        if (mute) begin
            r = '0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_sample_transmitter_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_sample_transmitter_if
//  Description : Sample input and I2S output bundle of the sample transmitter.
//                slave = the transmitter, master = the block feeding it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2s_sample_transmitter_if #(
    parameter int SAMPLE_WIDTH = apu_audio_pkg::SAMPLE_WIDTH
);
    import apu_audio_pkg::*;

    logic [SAMPLE_WIDTH-1:0] i_sample;
    logic                    i_mute;
    logic                    o_bclk;
    logic                    o_lrclk;
    logic                    o_sdata;
    logic                    o_sample_stb;

    modport master (
        output i_sample,
        output i_mute,
        input  o_bclk,
        input  o_lrclk,
        input  o_sdata,
        input  o_sample_stb
    );

    modport slave (
        input  i_sample,
        input  i_mute,
        output o_bclk,
        output o_lrclk,
        output o_sdata,
        output o_sample_stb
    );

endinterface
`default_nettype wire

// File: rtl/i2s_bit_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_bit_clock_divider
//  Description : Divides clk down to the I2S bit clock and flags the cycle on
//                whose closing edge bclk rises or falls.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_bit_clock_divider #(
    parameter int BCLK_DIV = 4
) (
    input  wire logic i_clk,
    input  wire logic i_rst,
    input  wire logic i_en,
    output logic      o_bclk,
    output logic      o_rise_stb,
    output logic      o_fall_stb
);
    import apu_audio_pkg::*;

    localparam int                 c_CNT_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BCLK_DIV - 1);

    generate
        if (BCLK_DIV < 1) begin : g_bad_bclk_div
            $error("i2s_bit_clock_divider: BCLK_DIV must be at least 1");
        end
    endgenerate

    logic [c_CNT_W-1:0] r_div_cnt;
    logic               r_bclk;
    logic               w_wrap;

    // The toggle strobes describe the edge at the end of the current cycle.
    assign w_wrap     = i_en && (r_div_cnt == c_CNT_LAST);
    assign o_rise_stb = w_wrap && !r_bclk;
    assign o_fall_stb = w_wrap &&  r_bclk;
    assign o_bclk     = r_bclk;

    // Half-period counter; bclk flips each time the counter wraps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (i_en) begin
            r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
            if (w_wrap) begin
                r_bclk <= ~r_bclk;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_sample_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_sample_transmitter
//  Description : Captures one mixer sample per I2S frame, converts it to
//                left-justified two's complement and shifts it out MSB first
//                in both the left and right slots.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_sample_transmitter #(
    parameter int SAMPLE_WIDTH = apu_audio_pkg::SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = apu_audio_pkg::I2S_SLOT_WIDTH,
    parameter int BCLK_DIV     = 4
) (
    input  wire logic               i_clk,
    input  wire logic               i_rst,
    i2s_sample_transmitter_if.slave bus
);
    import apu_audio_pkg::*;

    localparam int                 c_FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int                 c_P_W        = $clog2(c_FRAME_BITS);
    localparam logic [c_P_W-1:0]   c_P_LAST     = c_P_W'(c_FRAME_BITS - 1);
    localparam logic [c_P_W-1:0]   c_LR_FIRST   = c_P_W'(SLOT_WIDTH - 1);
    localparam logic [c_P_W-1:0]   c_LR_LAST    = c_P_W'(c_FRAME_BITS - 2);

    generate
        if (SLOT_WIDTH < SAMPLE_WIDTH) begin : g_bad_slot_width
            $error("i2s_sample_transmitter: SLOT_WIDTH must be at least SAMPLE_WIDTH");
        end
        if (SLOT_WIDTH > c_CONV_MAX_W) begin : g_slot_too_wide
            $error("i2s_sample_transmitter: SLOT_WIDTH exceeds conversion helper width");
        end
    endgenerate

    i2s_state_t              r_state;
    i2s_state_t              w_state_next;
    logic                    w_run;

    logic                    w_bclk;
    logic                    w_bclk_rise;
    logic                    w_bclk_fall;

    logic [c_P_W-1:0]        r_p;
    logic [c_P_W-1:0]        w_p_next;
    logic                    w_frame_start;
    logic [SLOT_WIDTH-1:0]   w_conv;
    logic [c_FRAME_BITS-1:0] r_shift;
    logic                    r_sdata;
    logic                    r_lrclk;
    logic                    r_sample_stb;

    // Mode register: RESET while rst is sampled high, RUN afterwards.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The first cycle after reset is already cycle 0 of the frame timing, so
    // the divider runs in RESET as soon as rst is low.
    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        case (r_state)
            ST_RESET: begin
                w_state_next = ST_RUN;
                w_run        = 1'b1;
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
                w_run        = 1'b1;
            end
            default: begin
                w_state_next = ST_RESET;
                w_run        = 1'b0;
            end
        endcase
    end

    i2s_bit_clock_divider #(
        .BCLK_DIV   (BCLK_DIV)
    ) u_bclk_div (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (w_run),
        .o_bclk     (w_bclk),
        .o_rise_stb (w_bclk_rise),
        .o_fall_stb (w_bclk_fall)
    );

    // A rising and a falling toggle can never be scheduled for the same edge.
    assert property (@(posedge i_clk) disable iff (i_rst) !(w_bclk_rise && w_bclk_fall));

    assign w_frame_start = (r_p == c_P_LAST);
    assign w_p_next      = w_frame_start ? '0 : r_p + 1'b1;
    assign w_conv        = SLOT_WIDTH'(sample_to_slot(c_CONV_MAX_W'(bus.i_sample),
                                                      SAMPLE_WIDTH, SLOT_WIDTH, bus.i_mute));

    // On each falling bclk: advance the bit position, update word select and
    // put the next bit on sdata; at the frame wrap, load both slots and emit
    // the first bit in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_p          <= c_P_LAST;
            r_shift      <= '0;
            r_sdata      <= 1'b0;
            r_lrclk      <= 1'b0;
            r_sample_stb <= 1'b0;
        end else begin
            r_sample_stb <= 1'b0;
            if (w_bclk_fall) begin
                r_p     <= w_p_next;
                r_lrclk <= (w_p_next >= c_LR_FIRST) && (w_p_next <= c_LR_LAST);
                if (w_frame_start) begin
                    r_sdata      <= w_conv[SLOT_WIDTH-1];
                    r_shift      <= {w_conv, w_conv} << 1;
                    r_sample_stb <= 1'b1;
                end else begin
                    r_sdata <= r_shift[c_FRAME_BITS-1];
                    r_shift <= r_shift << 1;
                end
            end
        end
    end

    assign bus.o_bclk       = w_bclk;
    assign bus.o_lrclk      = r_lrclk;
    assign bus.o_sdata      = r_sdata;
    assign bus.o_sample_stb = r_sample_stb;

endmodule
`default_nettype wire
